frag_imm_gen_stage: RTL and testbench
=====================================

Name: frag_imm_gen_stage

Overview:
- Pipelined, parametrised immediate generator for the decode path, positioned between the fetch buffer and the execute/branch unit.
- Per instruction it produces:
  - the XLEN-wide sign-extended immediate;
  - a one-hot-free type code;
  - an illegal-opcode flag;
  - the precomputed target `pc + imm`.
- Full-throughput valid/ready slice with a 2-entry skid buffer, so upstream ready is a registered signal.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Immediates are sign-extended from their top encoded bit to XLEN.
- PC_W, 32, PC width; must be <= XLEN. Target is truncated to PC_W.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_inst  in  32  raw RV32 instruction word
- in_pc  in  PC_W  PC of in_inst
- out_valid  out  1  main register holds a result
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  generated immediate
- out_type  out  3  0=NONE 1=I 2=S 3=B 4=U 5=J 6=Z (CSR uimm) 7=reserved
- out_target  out  PC_W  (in_pc + out_imm) mod 2^PC_W
- out_illegal  out  1  opcode not in supported set
- out_pc  out  PC_W  passthrough of in_pc

Behaviour:
- Decode is combinational on in_inst; results are registered. Latency is 1 cycle from accept (in_valid&in_ready) to out_valid.
- Opcode map:
  - OP 0110011 -> NONE, imm 0.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111 -> I, inst[31:20].
  - STORE 0100011 -> S, {inst[31:25],inst[11:7]}.
  - BRANCH 1100011 -> B, {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - LUI 0110111, AUIPC 0010111 -> U, {inst[31:12],12'h0}; sign-extended from bit 31 when XLEN=64.
  - JAL 1101111 -> J, {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - Anything else -> NONE, imm 0, out_illegal=1.
- Target adder: XLEN-wide add of zero-extended pc and imm, truncated to PC_W. Always computed regardless of type.
- Storage: main reg M (drives outputs) and skid reg S.
  - Accept when in_valid & in_ready.
  - Routing of an accepted word:
    - Goes to M if M is empty or (out_valid & out_ready).
    - Otherwise it goes to S.
  - When out_ready & M valid & S valid: M <= S, S emptied.
  - When out_ready & M valid & !S valid & no accept: M emptied.
  - in_ready is deasserted exactly while S is full; no accept can coincide with S full.
  - No data loss; no reorder; no duplicate. out_* stable while out_valid & !out_ready.
- Reset (async, any time, including mid-transfer):
  - M and S are invalidated immediately.
  - out_valid=0, in_ready=1.
  - out_imm, out_target, out_pc = 0; out_type=0; out_illegal=0.
  - Deassertion is taken synchronously by downstream logic; the first accept is allowed on the first clock edge after rst falls.
- Data registers need not be cleared except to satisfy the reset values above. All output values are held in M.

Optional Feature:
- Macro FRAG_IMM_ZICSR_EN.
- Defined:
  - SYSTEM opcode 1110011 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) -> type Z, imm = zero-extended inst[19:15], illegal=0.
  - Other SYSTEM funct3 values -> I-type decode (CSR address in imm[11:0]), illegal=0.
- Undefined: opcode 1110011 -> NONE, imm 0, illegal=1. Type code 6 is never produced.

Test Plan:
- XLEN=32, in_inst=0xFFF00093 (addi x1,x0,-1), pc=0x100, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, type=1, target=0x000000FF.
- in_inst=0x0080006F (jal x0,8), pc=0x100 -> imm=0x00000008, type=5, target=0x108; in_inst=0xFE000EE3 (beq -4), pc=0x200 -> imm=0xFFFFFFFC, type=3, target=0x1FC.
- XLEN=64: in_inst=0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000, type=4; in_inst=0x123450B7 -> imm=0x0000000012345000.
- Backpressure: out_ready=0, stream 3 back-to-back valid words A,B,C -> A in M, B in S, in_ready=0 one cycle after B accepted, C held upstream. Raise out_ready -> outputs A,B,C in order, one per cycle, no gaps after C accepted.
- Illegal/reset: in_inst=0x0000007F -> illegal=1, imm=0. With M and S full, assert rst mid-cycle -> out_valid=0 and in_ready=1 immediately, with all data outputs 0.
- FRAG_IMM_ZICSR_EN defined: in_inst=0x3401D073 (csrrwi, uimm=3) -> type=6, imm=0x3, illegal=0. Undefined: same input -> illegal=1, type=0.

Source files
------------

// File: rtl/frag_imm_gen_stage.sv
// Pipelined RV immediate generator with a 2-entry valid/ready skid slice.
// Optional macro FRAG_IMM_ZICSR_EN enables the CSR-immediate (Z) decode of SYSTEM.
module frag_imm_gen_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [PC_W-1:0] out_target,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
);

  localparam int unsigned TYPE_W = 3;

  localparam logic [TYPE_W-1:0] T_NONE = 3'd0;
  localparam logic [TYPE_W-1:0] T_I    = 3'd1;
  localparam logic [TYPE_W-1:0] T_S    = 3'd2;
  localparam logic [TYPE_W-1:0] T_B    = 3'd3;
  localparam logic [TYPE_W-1:0] T_U    = 3'd4;
  localparam logic [TYPE_W-1:0] T_J    = 3'd5;
`ifdef FRAG_IMM_ZICSR_EN
  localparam logic [TYPE_W-1:0] T_Z    = 3'd6;
`endif

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef FRAG_IMM_ZICSR_EN
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  typedef struct packed {
    logic [XLEN-1:0]   imm;
    logic [TYPE_W-1:0] typ;
    logic [PC_W-1:0]   target;
    logic              illegal;
    logic [PC_W-1:0]   pc;
  } slot_t;

  logic signed [31:0] imm32_c;
  logic [TYPE_W-1:0]  typ_c;
  logic               illegal_c;
  slot_t              dec_c;

  slot_t m_q;
  slot_t s_q;
  logic  s_valid;

  logic  accept_c;
  logic  pop_c;
  logic  m_valid_nxt_c;
  logic  s_valid_nxt_c;
  logic  load_m_in_c;
  logic  load_m_s_c;
  logic  load_s_c;

  // Decode to a 32-bit value already sign-extended from the top encoded bit.
  always_comb begin
    imm32_c   = '0;
    typ_c     = T_NONE;
    illegal_c = 1'b0;
    unique case (in_inst[6:0])
      OP_OP: ;
      OP_IMM, OP_LOAD, OP_JALR: begin
        typ_c   = T_I;
        imm32_c = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_STORE: begin
        typ_c   = T_S;
        imm32_c = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        typ_c   = T_B;
        imm32_c = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        typ_c   = T_U;
        imm32_c = {in_inst[31:12], 12'h000};
      end
      OP_JAL: begin
        typ_c   = T_J;
        imm32_c = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
      end
`ifdef FRAG_IMM_ZICSR_EN
      OP_SYSTEM: begin
        if (in_inst[14]) begin
          typ_c   = T_Z;
          imm32_c = {27'd0, in_inst[19:15]};
        end else begin
          typ_c   = T_I;
          imm32_c = {{20{in_inst[31]}}, in_inst[31:20]};
        end
      end
`endif
      default: illegal_c = 1'b1;
    endcase
  end

  // Widen to XLEN and form the branch/jump target from the zero-extended PC.
  always_comb begin
    dec_c         = '0;
    dec_c.imm     = XLEN'(imm32_c);
    dec_c.typ     = typ_c;
    dec_c.illegal = illegal_c;
    dec_c.pc      = in_pc;
    dec_c.target  = PC_W'(XLEN'(in_pc) + XLEN'(imm32_c));
  end

  // Skid control: new word fills M when M frees up, otherwise parks in S.
  always_comb begin
    accept_c      = in_valid & in_ready;
    pop_c         = out_valid & out_ready;
    m_valid_nxt_c = out_valid;
    s_valid_nxt_c = s_valid;
    load_m_in_c   = 1'b0;
    load_m_s_c    = 1'b0;
    load_s_c      = 1'b0;
    if (accept_c) begin
      if (!out_valid || pop_c) begin
        load_m_in_c   = 1'b1;
        m_valid_nxt_c = 1'b1;
      end else begin
        load_s_c      = 1'b1;
        s_valid_nxt_c = 1'b1;
      end
    end else if (pop_c) begin
      if (s_valid) begin
        load_m_s_c    = 1'b1;
        s_valid_nxt_c = 1'b0;
      end else begin
        m_valid_nxt_c = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s_valid   <= 1'b0;
      in_ready  <= 1'b1;
      m_q       <= '0;
      s_q       <= '0;
    end else begin
      out_valid <= m_valid_nxt_c;
      s_valid   <= s_valid_nxt_c;
      in_ready  <= ~s_valid_nxt_c;
      if (load_m_in_c) m_q <= dec_c;
      else if (load_m_s_c) m_q <= s_q;
      if (load_s_c) s_q <= dec_c;
    end
  end

  assign out_imm     = m_q.imm;
  assign out_type    = m_q.typ;
  assign out_target  = m_q.target;
  assign out_illegal = m_q.illegal;
  assign out_pc      = m_q.pc;

endmodule

// File: tb/tb_frag_imm_gen_stage.sv
// Bench for frag_imm_gen_stage: XLEN=32 and XLEN=64 instances on shared inputs,
// directed vectors plus randomized traffic against a queue-based reference model.
module tb_frag_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_target32, out_pc32;
  logic [2:0]  out_type32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_target64, out_pc64;
  logic [2:0]  out_type64;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
    logic [31:0] tgt;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  frag_imm_gen_stage #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_type(out_type32), .out_target(out_target32),
    .out_illegal(out_illegal32), .out_pc(out_pc32)
  );

  frag_imm_gen_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_type(out_type64), .out_target(out_target64),
    .out_illegal(out_illegal64), .out_pc(out_pc64)
  );

  function automatic longint sext(longint raw, int bits);
    longint half = longint'(1) <<< (bits - 1);
    if (raw >= half) return raw - (longint'(1) <<< bits);
    return raw;
  endfunction

  // Reference decode: field values as numbers, sign-extended arithmetically.
  function automatic exp_t model(logic [31:0] inst, logic [31:0] pc);
    exp_t   e;
    longint v = 0;
    longint f;
    logic [6:0] op = inst[6:0];
    e.typ = 3'd0;
    e.ill = 1'b0;
    case (op)
      7'h33: ;
      7'h13, 7'h03, 7'h67: begin
        e.typ = 3'd1; v = sext(longint'(inst >> 20), 12);
      end
      7'h23: begin
        f = longint'(inst >> 25) * 32 + longint'((inst >> 7) & 32'h1F);
        e.typ = 3'd2; v = sext(f, 12);
      end
      7'h63: begin
        f = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
          + longint'((inst >> 25) & 32'h3F) * 32 + longint'((inst >> 8) & 32'hF) * 2;
        e.typ = 3'd3; v = sext(f, 13);
      end
      7'h37, 7'h17: begin
        e.typ = 3'd4; v = sext(longint'(inst >> 12) * 4096, 32);
      end
      7'h6F: begin
        f = longint'(inst[31]) * (1 << 20) + longint'((inst >> 12) & 32'hFF) * (1 << 12)
          + longint'(inst[20]) * (1 << 11) + longint'((inst >> 21) & 32'h3FF) * 2;
        e.typ = 3'd5; v = sext(f, 21);
      end
`ifdef FRAG_IMM_ZICSR_EN
      7'h73: begin
        if (inst[14]) begin
          e.typ = 3'd6; v = longint'((inst >> 15) & 32'h1F);
        end else begin
          e.typ = 3'd1; v = sext(longint'(inst >> 20), 12);
        end
      end
`endif
      default: e.ill = 1'b1;
    endcase
    e.imm = 64'(v);
    e.tgt = 32'(longint'(pc) + v);
    e.pc  = pc;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_cnt++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_imm32 !== '0 || out_type32 !== '0
        || out_target32 !== '0 || out_illegal32 !== 1'b0 || out_pc32 !== '0)
      begin err_cnt++; $display("FAIL reset32: v=%b rdy=%b imm=%h typ=%0d tgt=%h ill=%b pc=%h, need v=0 rdy=1 rest 0",
        out_valid32, in_ready32, out_imm32, out_type32, out_target32, out_illegal32, out_pc32); end
    cmp_cnt++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || out_imm64 !== '0 || out_type64 !== '0
        || out_target64 !== '0 || out_illegal64 !== 1'b0 || out_pc64 !== '0)
      begin err_cnt++; $display("FAIL reset64: v=%b rdy=%b imm=%h, need v=0 rdy=1 imm=0",
        out_valid64, in_ready64, out_imm64); end
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] imm64;
    logic [2:0]  typ;
    logic        ill;
    logic [31:0] tgt;
  } vec_t;

  task automatic test_directed();
    vec_t v[9];
    v[0] = '{32'hFFF00093, 32'h100, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0, 32'h000000FF};
    v[1] = '{32'h0080006F, 32'h100, 64'h00000000_00000008, 3'd5, 1'b0, 32'h00000108};
    v[2] = '{32'hFE000EE3, 32'h200, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0, 32'h000001FC};
    v[3] = '{32'h800000B7, 32'h0,   64'hFFFFFFFF_80000000, 3'd4, 1'b0, 32'h80000000};
    v[4] = '{32'h123450B7, 32'h0,   64'h00000000_12345000, 3'd4, 1'b0, 32'h12345000};
    v[5] = '{32'h0000007F, 32'h40,  64'h0,                 3'd0, 1'b1, 32'h00000040};
    v[6] = '{32'hFE112C23, 32'h300, 64'hFFFFFFFF_FFFFFFF8, 3'd2, 1'b0, 32'h000002F8};
    v[7] = '{32'h002081B3, 32'h50,  64'h0,                 3'd0, 1'b0, 32'h00000050};
`ifdef FRAG_IMM_ZICSR_EN
    v[8] = '{32'h3401D073, 32'h1000, 64'h3,                3'd6, 1'b0, 32'h00001003};
`else
    v[8] = '{32'h3401D073, 32'h1000, 64'h0,                3'd0, 1'b1, 32'h00001000};
`endif
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_inst = v[i].inst; in_pc = v[i].pc; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cmp_cnt++;
      if (out_valid32 !== 1'b1 || out_imm32 !== v[i].imm64[31:0] || out_type32 !== v[i].typ
          || out_illegal32 !== v[i].ill || out_target32 !== v[i].tgt || out_pc32 !== v[i].pc)
        begin err_cnt++; $display("FAIL dir32[%0d] inst=%h: v=%b imm=%h typ=%0d ill=%b tgt=%h pc=%h, need imm=%h typ=%0d ill=%b tgt=%h",
          i, v[i].inst, out_valid32, out_imm32, out_type32, out_illegal32, out_target32, out_pc32,
          v[i].imm64[31:0], v[i].typ, v[i].ill, v[i].tgt); end
      cmp_cnt++;
      if (out_valid64 !== 1'b1 || out_imm64 !== v[i].imm64 || out_type64 !== v[i].typ
          || out_illegal64 !== v[i].ill || out_target64 !== v[i].tgt)
        begin err_cnt++; $display("FAIL dir64[%0d] inst=%h: imm=%h typ=%0d ill=%b tgt=%h, need imm=%h typ=%0d ill=%b tgt=%h",
          i, v[i].inst, out_imm64, out_type64, out_illegal64, out_target64,
          v[i].imm64, v[i].typ, v[i].ill, v[i].tgt); end
    end
    @(negedge clk);
    cmp_cnt++;
    if (out_valid32 !== 1'b0) begin err_cnt++; $display("FAIL drain: out_valid=%b need 0", out_valid32); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc[3] = '{32'h10, 32'h20, 32'h30};
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = exp_pc[0];
    @(negedge clk);
    in_pc = exp_pc[1];
    @(negedge clk);
    in_pc = exp_pc[2];
    cmp_cnt++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || out_pc32 !== exp_pc[0])
      begin err_cnt++; $display("FAIL bp_full: rdy=%b v=%b pc=%h, need rdy=0 v=1 pc=%h",
        in_ready32, out_valid32, out_pc32, exp_pc[0]); end
    @(negedge clk);
    cmp_cnt++;
    if (in_ready32 !== 1'b0 || out_pc32 !== exp_pc[0])
      begin err_cnt++; $display("FAIL bp_hold: rdy=%b pc=%h, need rdy=0 pc=%h", in_ready32, out_pc32, exp_pc[0]); end
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) in_valid = 1'b0;
      cmp_cnt++;
      if (out_valid32 !== 1'b1 || out_pc32 !== exp_pc[k] || out_target32 !== exp_pc[k] - 32'd1)
        begin err_cnt++; $display("FAIL bp_order[%0d]: v=%b pc=%h tgt=%h, need pc=%h",
          k, out_valid32, out_pc32, out_target32, exp_pc[k]); end
    end
    @(negedge clk);
    cmp_cnt++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1)
      begin err_cnt++; $display("FAIL bp_empty: v=%b rdy=%b, need v=0 rdy=1", out_valid32, in_ready32); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0080006F; in_pc = 32'hABC0;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    cmp_cnt++;
    if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0)
      begin err_cnt++; $display("FAIL rst_prefill: v=%b rdy=%b, need v=1 rdy=0", out_valid32, in_ready32); end
    #2 rst = 1'b1;
    #1;
    cmp_cnt++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_imm32 !== '0 || out_type32 !== '0
        || out_target32 !== '0 || out_pc32 !== '0 || out_illegal32 !== 1'b0 || out_valid64 !== 1'b0
        || out_imm64 !== '0)
      begin err_cnt++; $display("FAIL rst_mid: v=%b rdy=%b imm=%h typ=%0d tgt=%h pc=%h, need v=0 rdy=1 rest 0",
        out_valid32, in_ready32, out_imm32, out_type32, out_target32, out_pc32); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Random traffic: model occupancy is the queue size; outputs must track its head.
  task automatic test_random();
    logic [6:0] ops[12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F, 7'h0B};
    logic [31:0] r;
    logic        fire_in, fire_out;
    exp_t        h;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      cmp_cnt++;
      if (out_valid32 !== (q.size() > 0) || in_ready32 !== (q.size() < 2)
          || out_valid64 !== out_valid32 || in_ready64 !== in_ready32)
        begin err_cnt++; $display("FAIL rnd_flow c=%0d: v=%b rdy=%b occ=%0d", c, out_valid32, in_ready32, q.size()); end
      if (q.size() > 0) begin
        h = q[0];
        cmp_cnt++;
        if (out_imm32 !== h.imm[31:0] || out_imm64 !== h.imm || out_type32 !== h.typ
            || out_type64 !== h.typ || out_illegal32 !== h.ill || out_target32 !== h.tgt
            || out_target64 !== h.tgt || out_pc32 !== h.pc)
          begin err_cnt++; $display("FAIL rnd_data c=%0d: imm=%h typ=%0d ill=%b tgt=%h pc=%h, need imm=%h typ=%0d ill=%b tgt=%h pc=%h",
            c, out_imm64, out_type32, out_illegal32, out_target32, out_pc32, h.imm, h.typ, h.ill, h.tgt, h.pc); end
      end
      r = $urandom();
      in_inst   = {r[31:7], ops[$urandom_range(0, 11)]};
      in_pc     = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      fire_out  = out_valid32 && out_ready;
      fire_in   = in_valid && in_ready32;
      if (fire_out && q.size() > 0) void'(q.pop_front());
      if (fire_in) q.push_back(model(in_inst, in_pc));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
